// File: rtl/classical_room_reader_if.sv
// Host-side handshake bundle for classical_room_reader.
//   master : the host. It drives the provisioning and read requests and receives
//            the readies, the rd_ack pulse and the read result.
//   slave  : the reader. It receives the requests and drives the readies and the result.
// Signals:
//   prov_valid / prov_data / prov_ready : provisioning request with the value to store.
//   rd_valid / rd_ready                 : request for the single destructive read.
//   rd_ack / rd_data / rd_status        : one-cycle completion pulse with its result.
interface classical_room_reader_if;
    logic       prov_valid;
    logic [7:0] prov_data;
    logic       prov_ready;
    logic       rd_valid;
    logic       rd_ready;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic [1:0] rd_status;

    modport master (
        output prov_valid, prov_data, rd_valid,
        input  prov_ready, rd_ready, rd_ack, rd_data, rd_status
    );

    modport slave (
        input  prov_valid, prov_data, rd_valid,
        output prov_ready, rd_ready, rd_ack, rd_data, rd_status
    );
endinterface

// File: rtl/classical_room_reader.sv
// Single-shot reader for a write-once "room" register.
// The host provisions a value into the room. It may then request one destructive read.
// The reader strobes the room's read, checks output_enable and pad_enable, and waits
// up to FUSE_TIMEOUT cycles for the room's fuse_blow confirmation.
// It then reports the outcome with a one-cycle rd_ack.
// Ports:
//   clk, reset     : single clock; synchronous, active-high reset.
//   host           : handshake bundle (slave side). It carries provisioning, read
//                    request and read result.
//   alarm          : sticky; a fuse_blow was seen while no confirmation was pending.
//   room_init      : init strobe to the room register.
//   room_value_in  : value to the room register.
//   room_read      : read strobe to the room register.
//   room_value_out : room value_out; valid in the same cycle.
//   room_oe        : room output_enable.
//   room_pad_en    : room pad_enable.
//   room_fuse      : room fuse_blow; arrives one cycle after a valid read.
// rd_status: 0=OK, 1=COLLAPSED, 2=NOFUSE, 3=PADFAULT.
module classical_room_reader #(
    parameter int unsigned FUSE_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    classical_room_reader_if.slave  host,
    output logic                    alarm,
    output logic                    room_init,
    output logic [7:0]              room_value_in,
    output logic                    room_read,
    input  logic [7:0]              room_value_out,
    input  logic                    room_oe,
    input  logic                    room_pad_en,
    input  logic                    room_fuse
);

    typedef enum logic [2:0] {
        StIdle,
        StProvision,
        StArmed,
        StRead,
        StConfirm,
        StDone
    } state_e;

    localparam logic [1:0] StatusOk        = 2'd0;
    localparam logic [1:0] StatusCollapsed = 2'd1;
    localparam logic [1:0] StatusNoFuse    = 2'd2;
    localparam logic [1:0] StatusPadFault  = 2'd3;

    localparam logic [3:0] TimeoutCnt = 4'(FUSE_TIMEOUT);

    state_e     state_q;
    logic [7:0] capture_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_inc;
    logic       alarm_q;
    logic       room_init_q;
    logic [7:0] room_value_in_q;
    logic       room_read_q;
    logic       rd_ack_q;
    logic [7:0] rd_data_q;
    logic [1:0] rd_status_q;
    logic       accepting;

    assign cnt_inc   = cnt_q + 4'd1;
    assign accepting = (state_q == StIdle) || (state_q == StArmed);

    // Provisioning wins a tie, so the read side only reports ready when prov_valid is idle.
    assign host.prov_ready = accepting;
    assign host.rd_ready   = accepting && !host.prov_valid;
    assign host.rd_ack     = rd_ack_q;
    assign host.rd_data    = rd_data_q;
    assign host.rd_status  = rd_status_q;

    assign alarm         = alarm_q;
    assign room_init     = room_init_q;
    assign room_value_in = room_value_in_q;
    assign room_read     = room_read_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            capture_q       <= 8'h00;
            cnt_q           <= 4'd0;
            alarm_q         <= 1'b0;
            room_init_q     <= 1'b0;
            room_value_in_q <= 8'h00;
            room_read_q     <= 1'b0;
            rd_ack_q        <= 1'b0;
            rd_data_q       <= 8'h00;
            rd_status_q     <= StatusOk;
        end else begin
            // Strobes are single-cycle unless a state transition below re-asserts them.
            room_init_q <= 1'b0;
            room_read_q <= 1'b0;
            rd_ack_q    <= 1'b0;

            // A fuse is only legitimate as the confirmation of our own read.
            if (room_fuse && (state_q != StConfirm)) begin
                alarm_q <= 1'b1;
            end

            unique case (state_q)
                StIdle, StArmed: begin
                    if (host.prov_valid) begin
                        room_value_in_q <= host.prov_data;
                        room_init_q     <= 1'b1;
                        state_q         <= StProvision;
                    end else if (host.rd_valid) begin
                        room_read_q <= 1'b1;
                        state_q     <= StRead;
                    end
                end

                StProvision: begin
                    room_value_in_q <= 8'h00;
                    state_q         <= StArmed;
                end

                // room_read is high for this whole state.
                // The room's response is sampled at the closing edge.
                StRead: begin
                    if (!room_oe) begin
                        capture_q   <= 8'h00;
                        rd_status_q <= StatusCollapsed;
                        rd_data_q   <= 8'h00;
                        rd_ack_q    <= 1'b1;
                        state_q     <= StDone;
                    end else if (!room_pad_en) begin
                        capture_q   <= 8'h00;
                        rd_status_q <= StatusPadFault;
                        rd_data_q   <= 8'h00;
                        rd_ack_q    <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        capture_q <= room_value_out;
                        cnt_q     <= 4'd0;
                        state_q   <= StConfirm;
                    end
                end

                StConfirm: begin
                    if (room_fuse) begin
                        rd_status_q <= StatusOk;
                        rd_data_q   <= capture_q;
                        rd_ack_q    <= 1'b1;
                        state_q     <= StDone;
                    end else if (cnt_inc == TimeoutCnt) begin
                        capture_q   <= 8'h00;
                        rd_status_q <= StatusNoFuse;
                        rd_data_q   <= 8'h00;
                        rd_ack_q    <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                // The room has been consumed, so it is never ARMED again without re-provisioning.
                StDone: begin
                    capture_q <= 8'h00;
                    rd_data_q <= 8'h00;
                    state_q   <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_classical_room_reader.sv
// Testbench for classical_room_reader with a behavioural room register model.
// Each read request pushes its expected status, data and rd_ack cycle into a queue.
// A negedge monitor pops the queue on every rd_ack and compares the result.
module tb_classical_room_reader;

    localparam int unsigned FuseTimeout = 4;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [1:0] status;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    classical_room_reader_if host ();

    logic       alarm;
    logic       room_init;
    logic [7:0] room_value_in;
    logic       room_read;
    logic [7:0] room_value_out;
    logic       room_oe;
    logic       room_pad_en;
    logic       room_fuse;

    classical_room_reader #(
        .FUSE_TIMEOUT (FuseTimeout)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host           (host),
        .alarm          (alarm),
        .room_init      (room_init),
        .room_value_in  (room_value_in),
        .room_read      (room_read),
        .room_value_out (room_value_out),
        .room_oe        (room_oe),
        .room_pad_en    (room_pad_en),
        .room_fuse      (room_fuse)
    );

    // Room model: write-once value that a read consumes.
    // The fuse blows one cycle after a valid read has been seen.
    logic [7:0] room_val   = 8'h00;
    logic       room_armed = 1'b0;
    logic       fuse_p1    = 1'b0;
    logic       fuse_q     = 1'b0;
    logic       withhold   = 1'b0;
    logic       pad_ok     = 1'b1;
    logic       stray      = 1'b0;

    always @(posedge clk) begin
        fuse_p1 <= 1'b0;
        if (room_init) begin
            room_val   <= room_value_in;
            room_armed <= 1'b1;
        end
        if (room_read) begin
            if (room_armed && pad_ok && !withhold) fuse_p1 <= 1'b1;
            room_armed <= 1'b0;
            room_val   <= 8'h00;
        end
        fuse_q <= fuse_p1;
    end

    assign room_value_out = room_armed ? room_val : 8'h00;
    assign room_oe        = room_armed;
    assign room_pad_en    = pad_ok;
    assign room_fuse      = fuse_q | stray;

    int   n_tests     = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    int   read_pulses = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (room_read) read_pulses <= read_pulses + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (host.rd_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_rd_data"}, 32'(host.rd_data), 32'(e.data));
                check({e.name, "_rd_status"}, 32'(host.rd_status), 32'(e.status));
                check({e.name, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_provision(input string name, input logic [7:0] v);
        @(negedge clk);
        host.prov_data  = v;
        host.prov_valid = 1'b1;
        #1 check({name, "_prov_ready"}, 32'(host.prov_ready), 32'd1);
        @(posedge clk);
        #1 host.prov_valid = 1'b0;
        check({name, "_room_init_hi"}, 32'(room_init), 32'd1);
        check({name, "_room_value_in"}, 32'(room_value_in), 32'(v));
        @(posedge clk);
        #1 check({name, "_room_init_lo"}, 32'(room_init), 32'd0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check({name, "_ack_timeout"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_read(input string name, input logic [7:0] d, input logic [1:0] st,
                           input int lat);
        exp_t e;
        int   p0;
        @(negedge clk);
        host.rd_valid = 1'b1;
        #1 check({name, "_rd_ready"}, 32'(host.rd_ready), 32'd1);
        p0 = read_pulses;
        @(posedge clk);
        #1 host.rd_valid = 1'b0;
        e.name   = name;
        e.data   = d;
        e.status = st;
        e.cyc    = cyc + lat;
        exp_q.push_back(e);
        check({name, "_busy_prov_ready"}, 32'(host.prov_ready), 32'd0);
        wait_drain(name);
        repeat (2) @(posedge clk);
        #1 check({name, "_read_pulses"}, 32'(read_pulses - p0), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0;
        reset           = 1'b1;
        host.prov_valid = 1'b0;
        host.prov_data  = 8'h00;
        host.rd_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_ack", 32'(host.rd_ack), 32'd0);
        check("rst_rd_data", 32'(host.rd_data), 32'd0);
        check("rst_rd_status", 32'(host.rd_status), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_room_init", 32'(room_init), 32'd0);
        check("rst_room_read", 32'(room_read), 32'd0);
        check("rst_room_value_in", 32'(room_value_in), 32'd0);
        check("rst_prov_ready", 32'(host.prov_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Nominal provision and read: rd_ack three cycles after the accept edge
        do_provision("prov_3c", 8'h3C);
        do_read("read_ok", 8'h3C, 2'd0, 3);

        // A second read of the consumed room collapses
        do_read("read_collapsed", 8'h00, 2'd1, 1);

        // The fuse is withheld: NOFUSE is reported once the timeout count is reached
        do_provision("prov_a5", 8'hA5);
        withhold = 1'b1;
        do_read("read_nofuse", 8'h00, 2'd2, 1 + FuseTimeout);
        withhold = 1'b0;

        // Pad fault: the room drives oe but not pad_en
        do_provision("prov_5a", 8'h5A);
        pad_ok = 1'b0;
        do_read("read_padfault", 8'h00, 2'd3, 1);
        pad_ok = 1'b1;

        // Provisioning beats reading in the same cycle while ARMED
        do_provision("prov_11", 8'h11);
        @(negedge clk);
        host.prov_data  = 8'h77;
        host.prov_valid = 1'b1;
        host.rd_valid   = 1'b1;
        #1;
        check("prio_rd_ready", 32'(host.rd_ready), 32'd0);
        check("prio_prov_ready", 32'(host.prov_ready), 32'd1);
        p0 = read_pulses;
        @(posedge clk);
        #1;
        host.prov_valid = 1'b0;
        host.rd_valid   = 1'b0;
        check("prio_room_init", 32'(room_init), 32'd1);
        check("prio_room_value_in", 32'(room_value_in), 32'h77);
        repeat (3) @(posedge clk);
        #1 check("prio_no_read", 32'(read_pulses - p0), 32'd0);
        do_read("read_after_prio", 8'h77, 2'd0, 3);
        check("alarm_quiet", 32'(alarm), 32'd0);

        // A stray fuse in IDLE sets the sticky alarm
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        #1 check("alarm_set", 32'(alarm), 32'd1);
        repeat (5) @(posedge clk);
        #1 check("alarm_sticky", 32'(alarm), 32'd1);

        // Reset while in CONFIRM aborts the read without producing rd_ack
        do_provision("prov_99", 8'h99);
        withhold = 1'b1;
        @(negedge clk);
        host.rd_valid = 1'b1;
        @(posedge clk);
        #1 host.rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rd_ack", 32'(host.rd_ack), 32'd0);
        check("abort_room_read", 32'(room_read), 32'd0);
        check("abort_room_init", 32'(room_init), 32'd0);
        check("abort_alarm", 32'(alarm), 32'd0);
        check("abort_rd_data", 32'(host.rd_data), 32'd0);
        check("abort_rd_status", 32'(host.rd_status), 32'd0);
        check("abort_prov_ready", 32'(host.prov_ready), 32'd1);
        @(negedge clk);
        reset    = 1'b0;
        withhold = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
